// File: rtl/mlp_io_pkg.sv
// Shared definitions for the printed-MLP front end: default widths, loader states, quantizer.
// FEAT_ROUND_EN selects round-half-up with saturation instead of truncation.
package mlp_io_pkg;

  localparam int unsigned MLP_N_FEAT = 11;
  localparam int unsigned MLP_IN_W   = 8;
  localparam int unsigned MLP_Q_W    = 4;
  localparam int unsigned MLP_CLS_W  = 3;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RESYNC = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Reference quantizer at the default widths, for code that shares the classifier defaults
  function automatic logic [MLP_Q_W-1:0] quantize(input logic [MLP_IN_W-1:0] d);
`ifdef FEAT_ROUND_EN
    logic [MLP_Q_W:0] rnd;
    rnd = (MLP_Q_W+1)'(({1'b0, d} + (MLP_IN_W+1)'(1 << (MLP_IN_W - MLP_Q_W - 1)))
                       >> (MLP_IN_W - MLP_Q_W));
    return rnd[MLP_Q_W] ? {MLP_Q_W{1'b1}} : rnd[MLP_Q_W-1:0];
`else
    return MLP_Q_W'(d >> (MLP_IN_W - MLP_Q_W));
`endif
  endfunction

endpackage

// File: rtl/feat_quant.sv
// Combinational IN_W -> Q_W sample quantizer.
// FEAT_ROUND_EN: round-half-up with saturation; otherwise plain truncation.
module feat_quant
  import mlp_io_pkg::*;
#(
  parameter int unsigned IN_W = MLP_IN_W,
  parameter int unsigned Q_W  = MLP_Q_W
) (
  input  logic [IN_W-1:0] d,
  output logic [Q_W-1:0]  q
);

  localparam int unsigned SH = IN_W - Q_W;

`ifdef FEAT_ROUND_EN
  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SH - 1);

  // Sum carries one extra bit so a carry out of the top nibble means saturate
  logic [Q_W:0] rnd;
  assign rnd = (Q_W+1)'(({1'b0, d} + HALF) >> SH);
  assign q   = rnd[Q_W] ? {Q_W{1'b1}} : rnd[Q_W-1:0];
`else
  assign q = Q_W'(d >> SH);
`endif

endmodule

// File: rtl/feat_frame_loader.sv
// Streams quantized samples into the classifier feature vector, waits for it to settle,
// then returns the class index over a valid/ready handshake. Quantizer mode: FEAT_ROUND_EN.
module feat_frame_loader
  import mlp_io_pkg::*;
#(
  parameter int unsigned N_FEAT = MLP_N_FEAT,
  parameter int unsigned IN_W   = MLP_IN_W,
  parameter int unsigned Q_W    = MLP_Q_W,
  parameter int unsigned CLS_W  = MLP_CLS_W,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic [N_FEAT*Q_W-1:0] feat_vec,
  input  logic [CLS_W-1:0]      cls_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CLS_W-1:0]      m_class,
  output logic                  err_frame
);

  localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [N_FEAT*Q_W-1:0]   feat_nxt;
  logic [CLS_W-1:0]        class_nxt;
  logic                    err_nxt;
  logic                    open;
  logic                    take;
  logic [Q_W-1:0]          q;

  feat_quant #(.IN_W(IN_W), .Q_W(Q_W)) u_quant (
    .d (s_data),
    .q (q)
  );

  // Handshake flags decode the registered state only
  assign open    = (state == LOAD) || (state == RESYNC);
  assign s_ready = open && !rst;
  assign m_valid = (state == OUT);
  assign take    = s_valid && open;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    feat_nxt  = feat_vec;
    class_nxt = m_class;
    err_nxt   = 1'b0;
    unique case (state)
      LOAD: begin
        if (take) begin
          feat_nxt[idx*Q_W +: Q_W] = q;
          if (idx == IDX_W'(N_FEAT - 1)) begin
            idx_nxt = '0;
            if (s_last) begin
              state_nxt = mlp_io_pkg::SETTLE;
              cnt_nxt   = '0;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = RESYNC;
            end
          end else if (s_last) begin
            // Short frame: restart, stale slots get overwritten by the next frame
            err_nxt = 1'b1;
            idx_nxt = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      RESYNC: begin
        if (take && s_last) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      mlp_io_pkg::SETTLE: begin
        if (cnt == CNT_W'(SETTLE - 1)) begin
          class_nxt = cls_in;
          state_nxt = OUT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      OUT: begin
        if (m_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      cnt       <= '0;
      feat_vec  <= '0;
      m_class   <= '0;
      err_frame <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      feat_vec  <= feat_nxt;
      m_class   <= class_nxt;
      err_frame <= err_nxt;
    end
  end

endmodule
